// File: rtl/uart_if.sv
// Core-side UART handshake bundle between the CPU and the serial bridge.
// The core drives requests/acks; the bridge answers with status and data.
interface uart_if #(
    parameter int WORD = 32
);
    logic            ext_uart_start;
    logic [WORD-1:0] t_data;
    logic            ext_uart_busy;
    logic            ext_uart_clear;
    logic            ext_uart_ready;
    logic [WORD-1:0] r_data;

    modport master (
        output ext_uart_start,
        output t_data,
        output ext_uart_clear,
        input  ext_uart_busy,
        input  ext_uart_ready,
        input  r_data
    );

    modport slave (
        input  ext_uart_start,
        input  t_data,
        input  ext_uart_clear,
        output ext_uart_busy,
        output ext_uart_ready,
        output r_data
    );
endinterface

// File: rtl/uart_bridge.sv
// 8N1 UART bridge: one-byte transmitter and receiver with a held receive word.
// TX and RX run independently; all outputs are registered.
module uart_bridge #(
    parameter int WORD         = 32,
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic rst,
    uart_if.slave bus,
    output logic txd,
    input  logic rxd
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          tx_state;
    logic [CW-1:0]   tx_cnt;
    logic [2:0]      tx_bit;
    logic [7:0]      tx_shreg;
    logic            tx_busy;
    logic            tx_line;

    state_t          rx_state;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shreg;
    logic            rx_s1;
    logic            rx_s2;
    logic            rx_prev;
    logic            rx_ready;
    logic [WORD-1:0] rx_word;

    logic            unused_t_data;

    assign unused_t_data      = ^bus.t_data[WORD-1:8];
    assign txd                = tx_line;
    assign bus.ext_uart_busy  = tx_busy;
    assign bus.ext_uart_ready = rx_ready;
    assign bus.r_data         = rx_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
            tx_busy  <= 1'b0;
            tx_line  <= 1'b1;
        end else begin
            unique case (tx_state)
                IDLE: begin
                    if (bus.ext_uart_start && !tx_busy) begin
                        tx_shreg <= bus.t_data[7:0];
                        tx_state <= START;
                        tx_busy  <= 1'b1;
                        tx_line  <= 1'b0;
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                    end
                end
                START: begin
                    if (tx_cnt == LAST) begin
                        tx_cnt   <= '0;
                        tx_line  <= tx_shreg[0];
                        tx_state <= DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tx_cnt == LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_line  <= 1'b1;
                            tx_state <= STOP;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx_shreg <= tx_shreg >> 1;
                            tx_line  <= tx_shreg[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tx_cnt == LAST) begin
                        tx_cnt   <= '0;
                        tx_busy  <= 1'b0;
                        tx_state <= IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // Two-flop synchroniser plus one history flop for falling-edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shreg <= '0;
            rx_ready <= 1'b0;
            rx_word  <= '0;
        end else begin
            if (bus.ext_uart_clear)
                rx_ready <= 1'b0;
            unique case (rx_state)
                IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= START;
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                    end
                end
                START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= rx_s2 ? IDLE : DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (rx_cnt == LAST) begin
                        rx_cnt   <= '0;
                        rx_shreg <= {rx_s2, rx_shreg[7:1]};
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7)
                            rx_state <= STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (rx_cnt == LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= IDLE;
                        // Completion overrides a same-cycle clear.
                        if (rx_s2) begin
                            rx_ready <= 1'b1;
                            rx_word  <= {{(WORD-8){1'b0}}, rx_shreg};
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_bridge.sv
// Directed self-checking bench for uart_bridge with an 8-cycle bit period.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_bridge;
    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd_drv = 1'b1;
    logic loop = 1'b0;
    logic txd;
    logic rxd_w;
    logic r78;
    logic r79;
    int   checks = 0;
    int   errors = 0;

    uart_if #(.WORD(32)) bus ();

    assign rxd_w = loop ? txd : rxd_drv;

    uart_bridge #(.WORD(32), .CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .txd (txd),
        .rxd (rxd_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start a frame now; check every cycle of it; optionally poke start at cycle inj.
    task automatic tx_check(input logic [7:0] b, input int inj);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        bus.ext_uart_start = 1'b1;
        bus.t_data = {24'hFFFFFF, b};
        @(negedge clk);
        bus.ext_uart_start = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            chk("tx_txd", 32'(txd), 32'(f[(k-1)/CPB]));
            chk("tx_busy", 32'(bus.ext_uart_busy), 32'd1);
            bus.ext_uart_start = (k == inj);
            bus.t_data = 32'h0000_00AA;
            @(negedge clk);
        end
        chk("tx_end_busy", 32'(bus.ext_uart_busy), 32'd0);
        chk("tx_end_txd", 32'(txd), 32'd1);
    endtask

    // Drive one frame on rxd starting now; optional clear in the completion cycle.
    task automatic rx_send(input logic [7:0] b, input logic stop,
                           input logic clr);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 80; i++) begin
            rxd_drv = f[i/CPB];
            bus.ext_uart_clear = clr && (i == 78);
            if (i == 78) r78 = bus.ext_uart_ready;
            if (i == 79) r79 = bus.ext_uart_ready;
            @(negedge clk);
        end
        rxd_drv = 1'b1;
        bus.ext_uart_clear = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!bus.ext_uart_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.ext_uart_ready), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.ext_uart_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.ext_uart_busy), 32'd0);
    endtask

    task automatic do_clear();
        bus.ext_uart_clear = 1'b1;
        @(negedge clk);
        bus.ext_uart_clear = 1'b0;
    endtask

    initial begin
        bus.ext_uart_start = 1'b0;
        bus.ext_uart_clear = 1'b0;
        bus.t_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_busy", 32'(bus.ext_uart_busy), 32'd0);
        chk("rst_ready", 32'(bus.ext_uart_ready), 32'd0);
        chk("rst_rdata", bus.r_data, 32'd0);
        @(negedge clk);

        // 1: single frame, upper t_data bits set
        tx_check(8'h55, 0);
        repeat (5) @(negedge clk);

        // 2: ignored start mid-frame, then back-to-back start as busy falls
        tx_check(8'h55, 20);
        tx_check(8'hAA, 0);
        repeat (5) @(negedge clk);

        // 3: receive, hold, clear
        rx_send(8'hA5, 1'b1, 1'b0);
        chk("rx_pre_ready", 32'(r78), 32'd0);
        chk("rx_edge_ready", 32'(r79), 32'd1);
        chk("rx_ready", 32'(bus.ext_uart_ready), 32'd1);
        chk("rx_data", bus.r_data, 32'h0000_00A5);
        repeat (50) @(negedge clk);
        chk("rx_hold_ready", 32'(bus.ext_uart_ready), 32'd1);
        chk("rx_hold_data", bus.r_data, 32'h0000_00A5);
        do_clear();
        chk("rx_clr_ready", 32'(bus.ext_uart_ready), 32'd0);
        chk("rx_clr_data", bus.r_data, 32'h0000_00A5);

        // 4: glitch, framing error, then good frame
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_rdata", bus.r_data, 32'd0);
        rxd_drv = 1'b0;
        repeat (3) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_ready", 32'(bus.ext_uart_ready), 32'd0);
        rx_send(8'h3C, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        chk("ferr_ready", 32'(bus.ext_uart_ready), 32'd0);
        chk("ferr_data", bus.r_data, 32'd0);
        rx_send(8'h3C, 1'b1, 1'b0);
        chk("good_ready", 32'(bus.ext_uart_ready), 32'd1);
        chk("good_data", bus.r_data, 32'h0000_003C);
        do_clear();
        repeat (10) @(negedge clk);

        // 5: clear on completion cycle, then overrun
        rx_send(8'h12, 1'b1, 1'b1);
        chk("simul_ready", 32'(bus.ext_uart_ready), 32'd1);
        chk("simul_data", bus.r_data, 32'h0000_0012);
        repeat (10) @(negedge clk);
        rx_send(8'h34, 1'b1, 1'b0);
        chk("ovr_ready", 32'(bus.ext_uart_ready), 32'd1);
        chk("ovr_data", bus.r_data, 32'h0000_0034);
        do_clear();

        // 6: reset mid-TX, then loopback of three back-to-back frames
        bus.ext_uart_start = 1'b1;
        bus.t_data = 32'h0000_0055;
        @(negedge clk);
        bus.ext_uart_start = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_txd", 32'(txd), 32'd1);
        chk("rst_mid_busy", 32'(bus.ext_uart_busy), 32'd0);
        loop = 1'b1;
        repeat (20) @(negedge clk);
        begin
            logic [7:0] seq [3];
            seq[0] = 8'h00;
            seq[1] = 8'hFF;
            seq[2] = 8'h81;
            for (int j = 0; j < 3; j++) begin
                wait_idle("loop_idle");
                bus.ext_uart_start = 1'b1;
                bus.t_data = {24'h0, seq[j]};
                @(negedge clk);
                bus.ext_uart_start = 1'b0;
                chk("loop_busy", 32'(bus.ext_uart_busy), 32'd1);
                wait_ready("loop_ready");
                chk("loop_data", bus.r_data, {24'h0, seq[j]});
                do_clear();
                chk("loop_clr", 32'(bus.ext_uart_ready), 32'd0);
            end
        end
        repeat (100) @(negedge clk);
        chk("loop_final_ready", 32'(bus.ext_uart_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
